video_timing_gen: RTL and testbench
===================================

# video_timing_gen

Raster timing source that drives the sync and pixel-position signals consumed by the video arbiter and its pixel sources. It counts pixel ticks across a programmable horizontal/vertical raster and emits registered pixel coordinates, an active-area flag, line/frame start strobes, and hsync/vsync. The syncs are delayed by a programmable number of pixel ticks so they stay aligned with pixels that pass through downstream render and arbitration pipelines.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (ticks)
- H_SYNC, 96, hsync pulse width (ticks)
- H_BP, 48, horizontal back porch (ticks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, hsync asserted level (0 = active-low)
- V_POL, 0, vsync asserted level
- SYNC_DELAY, 2, sync lag behind o_x/o_y in pixel ticks, legal range 0..8
- Derived: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525); XW = clogb2(H_TOTAL); YW = clogb2(V_TOTAL)

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  reset, asynchronous assert, active-low
- i_pix_en  in  1  pixel tick enable; all state advances only when high
- o_x  out  XW  current horizontal count, 0..H_TOTAL-1
- o_y  out  YW  current vertical count, 0..V_TOTAL-1
- o_active  out  1  high when o_x < H_ACTIVE and o_y < V_ACTIVE
- o_line_start  out  1  one-clock strobe when o_x becomes 0
- o_frame_start  out  1  one-clock strobe when (o_x,o_y) becomes (0,0)
- o_hsync  out  1  horizontal sync, delayed SYNC_DELAY ticks
- o_vsync  out  1  vertical sync, delayed SYNC_DELAY ticks

## Operation
- The horizontal counter hc and the vertical counter vc are registered. On a tick (i_pix_en=1), hc increments. At H_TOTAL-1 it wraps to 0 and vc increments. vc wraps from V_TOTAL-1 to 0 on that same tick.
- Reset state is hc=H_TOTAL-1 and vc=V_TOTAL-1, so the first tick after reset lands on (0,0).
- o_x = hc and o_y = vc, both registered. o_active is registered and decoded from the next counter values, so it is coincident with o_x/o_y.
- Raw hsync is asserted (level H_POL) for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]. Default range is 656..751.
- Raw vsync is asserted (level V_POL) for vc in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] over whole lines. Default range is 490..491. It changes together with hc=0.
- Raw syncs pass through a SYNC_DELAY-deep shift register that advances only on ticks.
  - SYNC_DELAY=0 bypasses the shift register. The syncs are then coincident with o_x/o_y.
- o_line_start is set on the clock edge of a tick where the next hc is 0. o_frame_start is set on the tick where the next (hc,vc) is (0,0). Both strobes clear on the next clock edge regardless of i_pix_en, so each is exactly one i_clk wide.
- If i_pix_en is low, all registers hold, except that the strobes clear.

## Timing
- Reset values:
  - o_x = H_TOTAL-1, o_y = V_TOTAL-1
  - o_active = 0, o_line_start = 0, o_frame_start = 0
  - o_hsync = ~H_POL, o_vsync = ~V_POL, and all delay stages hold these inactive levels
- Assertion of i_rst_n=0 forces reset values immediately, without a clock, including mid-frame or mid-sync-pulse. Deassertion is treated as synchronous to i_clk by the integrator.
- Latency: (o_x,o_y,o_active) update on the clock edge of each tick. Syncs lag by exactly SYNC_DELAY ticks, not clocks.
- Default frame length is 800*525 = 420000 ticks. With continuous i_pix_en, o_frame_start pulses every 420000 clocks.
- The first tick after reset produces (0,0), o_active=1, o_line_start=1 and o_frame_start=1 on the same edge.
- The first SYNC_DELAY ticks after reset output inactive sync levels.

## Test plan
- Reset: hold i_rst_n=0 with no clock edges. Required: o_x=799, o_y=524, o_active=0, o_hsync=1, o_vsync=1, strobes 0.
  - Release, then one tick. Required: o_x=0, o_y=0, o_active=1, o_frame_start=1 for one clock.
- Full frame, i_pix_en=1, SYNC_DELAY=0:
  - o_hsync is 0 for exactly 96 consecutive clocks starting at o_x=656, every line.
  - o_vsync is 0 from (0,490) through (799,491).
  - o_active is high for 307200 clocks per frame.
- Wrap: at (799,479) the next tick gives (0,480), o_line_start=1, o_active=0. At (799,524) the next tick gives (0,0) and o_frame_start=1.
- Enable gating: i_pix_en high one clock in four. Required: o_x advances once per four clocks, strobes stay one clock wide, o_frame_start period is 1680000 clocks.
- SYNC_DELAY=2: the hsync falling edge occurs on the tick where o_x becomes 658, and its width is still 96 ticks.
  - With i_pix_en stalled mid-pulse, the sync level holds.
- Async reset: drop i_rst_n mid-hsync at (700,100). Required: outputs take reset values before the next i_clk edge. After release, the sequence restarts at (0,0).

Source files
------------

// File: rtl/video_timing_gen.sv
// video_timing_gen: programmable raster counter with registered position, line/frame strobes
// and hsync/vsync delayed by SYNC_DELAY pixel ticks to match downstream pipelines.
module video_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit H_POL      = 1'b0,
  parameter bit V_POL      = 1'b0,
  parameter int SYNC_DELAY = 2,
  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int XW        = $clog2(H_TOTAL),
  localparam int YW        = $clog2(V_TOTAL)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_pix_en,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic          o_active,
  output logic          o_line_start,
  output logic          o_frame_start,
  output logic          o_hsync,
  output logic          o_vsync
);
  localparam int HS0 = H_ACTIVE + H_FP;
  localparam int HS1 = HS0 + H_SYNC - 1;
  localparam int VS0 = V_ACTIVE + V_FP;
  localparam int VS1 = VS0 + V_SYNC - 1;
  logic [XW-1:0] x_n;
  logic [YW-1:0] y_n;
  logic h_wrap, act_n, hs_n, vs_n, hs_q, vs_q;
  // everything registered is decoded from the next position so it lines up with o_x/o_y
  always_comb begin
    h_wrap = o_x == XW'(H_TOTAL - 1);
    x_n    = h_wrap ? '0 : o_x + 1'b1;
    y_n    = !h_wrap ? o_y : (o_y == YW'(V_TOTAL - 1)) ? '0 : o_y + 1'b1;
    act_n  = (x_n < XW'(H_ACTIVE)) && (y_n < YW'(V_ACTIVE));
    hs_n   = (x_n >= XW'(HS0) && x_n <= XW'(HS1)) ? H_POL : ~H_POL;
    vs_n   = (y_n >= YW'(VS0) && y_n <= YW'(VS1)) ? V_POL : ~V_POL;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_x           <= XW'(H_TOTAL - 1);
      o_y           <= YW'(V_TOTAL - 1);
      o_active      <= 1'b0;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
      hs_q          <= ~H_POL;
      vs_q          <= ~V_POL;
    end else begin
      o_line_start  <= i_pix_en && x_n == '0;
      o_frame_start <= i_pix_en && x_n == '0 && y_n == '0;
      if (i_pix_en) begin
        o_x      <= x_n;
        o_y      <= y_n;
        o_active <= act_n;
        hs_q     <= hs_n;
        vs_q     <= vs_n;
      end
    end
  end
  if (SYNC_DELAY == 0) begin : g_bypass
    assign o_hsync = hs_q;
    assign o_vsync = vs_q;
  end else begin : g_delay
    logic [SYNC_DELAY-1:0] hsr, vsr;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        hsr <= {SYNC_DELAY{~H_POL}};
        vsr <= {SYNC_DELAY{~V_POL}};
      end else if (i_pix_en) begin
        hsr <= SYNC_DELAY'({hsr, hs_q});
        vsr <= SYNC_DELAY'({vsr, vs_q});
      end
    end
    assign o_hsync = hsr[SYNC_DELAY-1];
    assign o_vsync = vsr[SYNC_DELAY-1];
  end
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: three raster configurations driven by shared random tick enables,
// scored against a position-from-tick-count reference model.
module tb_video_timing_gen;
  typedef struct { int x, y, act, ls, fs, hs, vs; } exp_t;
  typedef struct { exp_t a, b, d; } trio_t;

  logic clk, rst_n, pix_en;
  logic [3:0] a_x;
  logic [2:0] a_y;
  logic a_act, a_ls, a_fs, a_hs, a_vs;
  logic [3:0] b_x;
  logic [2:0] b_y;
  logic b_act, b_ls, b_fs, b_hs, b_vs;
  logic [9:0] d_x, d_y;
  logic d_act, d_ls, d_fs, d_hs, d_vs;
  int checks = 0, errors = 0;
  longint t = 0;
  trio_t q[$];
  trio_t me;

  video_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
    .V_SYNC(2), .V_BP(1), .H_POL(1'b0), .V_POL(1'b0), .SYNC_DELAY(2)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en), .o_x(a_x), .o_y(a_y), .o_active(a_act),
    .o_line_start(a_ls), .o_frame_start(a_fs), .o_hsync(a_hs), .o_vsync(a_vs));

  video_timing_gen #(.H_ACTIVE(5), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(2),
    .V_SYNC(1), .V_BP(1), .H_POL(1'b1), .V_POL(1'b1), .SYNC_DELAY(0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en), .o_x(b_x), .o_y(b_y), .o_active(b_act),
    .o_line_start(b_ls), .o_frame_start(b_fs), .o_hsync(b_hs), .o_vsync(b_vs));

  video_timing_gen dut_d (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en), .o_x(d_x), .o_y(d_y), .o_active(d_act),
    .o_line_start(d_ls), .o_frame_start(d_fs), .o_hsync(d_hs), .o_vsync(d_vs));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Raster position is simply (reset position + ticks) mod frame size; syncs look d ticks back.
  function automatic exp_t model(input int ha, hf, hw, hb, va, vf, vw, vb, hp, vp, d,
                                 input longint tk, input bit stb);
    longint ht, vt, tot, p, qq;
    exp_t e;
    ht = longint'(ha + hf + hw + hb);
    vt = longint'(va + vf + vw + vb);
    tot = ht * vt;
    p = (tot - 1 + tk) % tot;
    e.x = int'(p % ht);
    e.y = int'(p / ht);
    e.act = (e.x < ha && e.y < va) ? 1 : 0;
    e.ls = (stb && e.x == 0) ? 1 : 0;
    e.fs = (stb && p == 0) ? 1 : 0;
    e.hs = 1 - hp;
    e.vs = 1 - vp;
    if (tk >= longint'(d)) begin
      qq = (tot - 1 + tk - longint'(d)) % tot;
      if (qq % ht >= ha + hf && qq % ht < ha + hf + hw) e.hs = hp;
      if (qq / ht >= va + vf && qq / ht < va + vf + vw) e.vs = vp;
    end
    return e;
  endfunction

  function automatic trio_t models(input longint tk, input bit stb);
    trio_t r;
    r.a = model(8, 2, 3, 2, 4, 1, 2, 1, 0, 0, 2, tk, stb);
    r.b = model(5, 1, 2, 1, 3, 2, 1, 1, 1, 1, 0, tk, stb);
    r.d = model(640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 2, tk, stb);
    return r;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", n, act, exp, $time);
    end
  endtask

  task automatic cmp(input string tag, input exp_t e, input logic [31:0] x, y,
                     input logic act, ls, fs, hs, vs);
    chk({tag, ".x"}, x, 32'(e.x));
    chk({tag, ".y"}, y, 32'(e.y));
    chk({tag, ".active"}, 32'(act), 32'(e.act));
    chk({tag, ".line_start"}, 32'(ls), 32'(e.ls));
    chk({tag, ".frame_start"}, 32'(fs), 32'(e.fs));
    chk({tag, ".hsync"}, 32'(hs), 32'(e.hs));
    chk({tag, ".vsync"}, 32'(vs), 32'(e.vs));
  endtask

  task automatic cmp_all(input trio_t e);
    cmp("a", e.a, 32'(a_x), 32'(a_y), a_act, a_ls, a_fs, a_hs, a_vs);
    cmp("b", e.b, 32'(b_x), 32'(b_y), b_act, b_ls, b_fs, b_hs, b_vs);
    cmp("d", e.d, 32'(d_x), 32'(d_y), d_act, d_ls, d_fs, d_hs, d_vs);
  endtask

  // Stimulus side: choose the enable for the coming edge and queue what it must produce.
  task automatic step(input bit en);
    @(negedge clk);
    pix_en = en;
    t = t + longint'(en);
    q.push_back(models(t, en));
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        me = q.pop_front();
        cmp_all(me);
      end
    end
  end

  initial begin
    bit found;
    rst_n = 1;
    pix_en = 0;
    #1 rst_n = 0;
    #2;
    cmp_all(models(0, 0));
    chk("d.reset_x", 32'(d_x), 799);
    chk("d.reset_y", 32'(d_y), 524);
    @(negedge clk);
    rst_n = 1;
    step(1);
    step(0);
    step(0);
    for (int i = 0; i < 1500; i++) step($urandom_range(0, 3) != 0);
    for (int i = 0; i < 800; i++) step(i % 4 == 0);
    for (int i = 0; i < 1000; i++) step(1);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      step(1);
      if (q[$].a.hs == 0) found = 1;
    end
    chk("a.hsync_pulse_reached", 32'(found), 1);
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    t = 0;
    cmp_all(models(0, 0));
    repeat (2) @(negedge clk);
    pix_en = 0;
    rst_n = 1;
    for (int i = 0; i < 400; i++) step($urandom_range(0, 1) != 0);
    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
